// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS pipeline: load-use and
// branch-in-ID stalls, IF-ID flush, memory-busy freeze, and saturating statistics.
module hazard_ctrl #(
    parameter int CW      = 16,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [4:0]    IFID_Rs,
    input  logic [4:0]    IFID_Rt,
    input  logic          IFID_uses_rt,
    input  logic          IFID_is_branch,
    input  logic          IDEX_mem_read,
    input  logic          IDEX_reg_write,
    input  logic [4:0]    IDEX_Rd,
    input  logic          EXMEM_mem_read,
    input  logic [4:0]    EXMEM_Rd,
    input  logic          branch_taken,
    input  logic          jump,
    input  logic          dmem_busy,
    input  logic          clr_stats,
    output logic          pc_write,
    output logic          IFID_write,
    output logic          IFID_flush,
    output logic          IDEX_bubble,
    output logic          pipe_freeze,
    output logic          freeze_err,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt,
    output logic [CW-1:0] freeze_cnt
);

    localparam int            TW      = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT);
    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic {RUN, FREEZE} state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          err_q, err_d;
    logic [CW-1:0] stall_q, stall_d;
    logic [CW-1:0] flush_q, flush_d;
    logic [CW-1:0] frz_q, frz_d;

    logic match_ex, match_mem, hz;

    always_comb begin
        match_ex  = (IDEX_Rd != 5'd0) &&
                    (IDEX_Rd == IFID_Rs || (IFID_uses_rt && IDEX_Rd == IFID_Rt));
        match_mem = (EXMEM_Rd != 5'd0) &&
                    (EXMEM_Rd == IFID_Rs || (IFID_uses_rt && EXMEM_Rd == IFID_Rt));
        hz = (IDEX_mem_read && match_ex)
           | (IFID_is_branch && IDEX_reg_write && match_ex)
           | (IFID_is_branch && EXMEM_mem_read && match_mem);
    end

    // Leaving FREEZE decodes like RUN in the same cycle, so both states share
    // one priority chain: freeze over stall over flush.
    always_comb begin
        pc_write    = 1'b0;
        IFID_write  = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_bubble = 1'b0;
        pipe_freeze = 1'b0;
        if (dmem_busy) begin
            pipe_freeze = 1'b1;
        end else if (hz) begin
            IDEX_bubble = 1'b1;
        end else begin
            pc_write   = 1'b1;
            IFID_write = 1'b1;
            IFID_flush = branch_taken | jump;
        end
    end

    always_comb begin
        state_d = dmem_busy ? FREEZE : RUN;
        timer_d = '0;
        unique case (state_q)
            RUN:    if (dmem_busy) timer_d = TW'(1);
            FREEZE: if (dmem_busy) timer_d = (timer_q == T_MAX) ? timer_q : timer_q + TW'(1);
            default: timer_d = '0;
        endcase

        stall_d = (IDEX_bubble && stall_q != CNT_MAX) ? stall_q + CW'(1) : stall_q;
        flush_d = (IFID_flush  && flush_q != CNT_MAX) ? flush_q + CW'(1) : flush_q;
        frz_d   = (pipe_freeze && frz_q   != CNT_MAX) ? frz_q   + CW'(1) : frz_q;
        err_d   = err_q | (dmem_busy && (timer_d == T_MAX));

        if (clr_stats) begin
            stall_d = '0;
            flush_d = '0;
            frz_d   = '0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            timer_q <= '0;
            err_q   <= 1'b0;
            stall_q <= '0;
            flush_q <= '0;
            frz_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
            frz_q   <= frz_d;
        end
    end

    assign freeze_err = err_q;
    assign stall_cnt  = stall_q;
    assign flush_cnt  = flush_q;
    assign freeze_cnt = frz_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomised scoreboard bench for hazard_ctrl: a rule-level model predicts each
// cycle's outputs and counters; a monitor on the falling edge compares them.
module tb_hazard_ctrl;

    localparam int CW      = 4;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    IFID_Rs, IFID_Rt, IDEX_Rd, EXMEM_Rd;
    logic          IFID_uses_rt, IFID_is_branch, IDEX_mem_read, IDEX_reg_write;
    logic          EXMEM_mem_read, branch_taken, jump, dmem_busy, clr_stats;
    logic          pc_write, IFID_write, IFID_flush, IDEX_bubble, pipe_freeze, freeze_err;
    logic [CW-1:0] stall_cnt, flush_cnt, freeze_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .IFID_Rs(IFID_Rs), .IFID_Rt(IFID_Rt), .IFID_uses_rt(IFID_uses_rt),
        .IFID_is_branch(IFID_is_branch), .IDEX_mem_read(IDEX_mem_read),
        .IDEX_reg_write(IDEX_reg_write), .IDEX_Rd(IDEX_Rd),
        .EXMEM_mem_read(EXMEM_mem_read), .EXMEM_Rd(EXMEM_Rd),
        .branch_taken(branch_taken), .jump(jump), .dmem_busy(dmem_busy),
        .clr_stats(clr_stats),
        .pc_write(pc_write), .IFID_write(IFID_write), .IFID_flush(IFID_flush),
        .IDEX_bubble(IDEX_bubble), .pipe_freeze(pipe_freeze), .freeze_err(freeze_err),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    typedef struct packed {
        logic       rst;
        logic [4:0] rs, rt;
        logic       uses_rt, is_branch, idex_mr, idex_rw;
        logic [4:0] idex_rd;
        logic       exmem_mr;
        logic [4:0] exmem_rd;
        logic       taken, jump, busy, clr;
    } stim_t;

    typedef struct {
        bit pc_write, ifid_write, ifid_flush, bubble, freeze, err;
        int stall, flush, frz;
    } exp_t;

    exp_t  exp_q[$];
    stim_t cur;
    exp_t  cur_exp;
    int    m_stall, m_flush, m_frz, m_run;
    bit    m_err;
    int    vectors = 0;
    int    miscompares = 0;
    bit    done = 0;

    function automatic bit reads(input logic [4:0] r, input stim_t s);
        return (r != 0) && (r == s.rs || (s.uses_rt && r == s.rt));
    endfunction

    function automatic exp_t predict(input stim_t s);
        exp_t e;
        bit   hazard;
        hazard = (s.idex_mr && reads(s.idex_rd, s))
              || (s.is_branch && s.idex_rw && reads(s.idex_rd, s))
              || (s.is_branch && s.exmem_mr && reads(s.exmem_rd, s));
        e = '{default: 0};
        if (s.busy)        e.freeze = 1;
        else if (hazard)   e.bubble = 1;
        else begin
            e.pc_write   = 1;
            e.ifid_write = 1;
            e.ifid_flush = s.taken || s.jump;
        end
        e.err   = m_err;
        e.stall = m_stall;
        e.flush = m_flush;
        e.frz   = m_frz;
        return e;
    endfunction

    // Advance the model across one rising edge using the inputs of the cycle just ended.
    task automatic modelEdge();
        if (cur.rst) begin
            m_stall = 0; m_flush = 0; m_frz = 0; m_err = 0; m_run = 0;
        end else begin
            if (cur.clr) begin
                m_stall = 0; m_flush = 0; m_frz = 0; m_err = 0;
            end else begin
                if (cur_exp.bubble)     m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
                if (cur_exp.ifid_flush) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
                if (cur_exp.freeze)     m_frz   = (m_frz   < CMAX) ? m_frz   + 1 : CMAX;
                if (cur.busy && m_run + 1 >= TIMEOUT) m_err = 1;
            end
            m_run = cur.busy ? ((m_run < TIMEOUT) ? m_run + 1 : TIMEOUT) : 0;
        end
    endtask

    task automatic drive(input stim_t s);
        rst            = s.rst;
        IFID_Rs        = s.rs;
        IFID_Rt        = s.rt;
        IFID_uses_rt   = s.uses_rt;
        IFID_is_branch = s.is_branch;
        IDEX_mem_read  = s.idex_mr;
        IDEX_reg_write = s.idex_rw;
        IDEX_Rd        = s.idex_rd;
        EXMEM_mem_read = s.exmem_mr;
        EXMEM_Rd       = s.exmem_rd;
        branch_taken   = s.taken;
        jump           = s.jump;
        dmem_busy      = s.busy;
        clr_stats      = s.clr;
    endtask

    task automatic applyStimulus(input stim_t s);
        @(posedge clk);
        modelEdge();
        #1;
        drive(s);
        cur     = s;
        cur_exp = predict(s);
        exp_q.push_back(cur_exp);
        vectors++;
    endtask

    task automatic checkOutput(input string name, input int act, input int expv);
        if (act != expv) begin
            miscompares++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("pc_write",    int'(pc_write),    int'(e.pc_write));
            checkOutput("IFID_write",  int'(IFID_write),  int'(e.ifid_write));
            checkOutput("IFID_flush",  int'(IFID_flush),  int'(e.ifid_flush));
            checkOutput("IDEX_bubble", int'(IDEX_bubble), int'(e.bubble));
            checkOutput("pipe_freeze", int'(pipe_freeze), int'(e.freeze));
            checkOutput("freeze_err",  int'(freeze_err),  int'(e.err));
            checkOutput("stall_cnt",   int'(stall_cnt),   e.stall);
            checkOutput("flush_cnt",   int'(flush_cnt),   e.flush);
            checkOutput("freeze_cnt",  int'(freeze_cnt),  e.frz);
        end
    end

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    initial begin
        stim_t s;
        int    burst;
        cur = idle();
        cur.rst = 1;
        drive(cur);
        m_stall = 0; m_flush = 0; m_frz = 0; m_err = 0; m_run = 0;
        cur_exp = predict(cur);

        applyStimulus(cur);
        repeat (2) applyStimulus(idle());

        // lw $2 in EX, add $3,$2,$4 in ID
        s = idle(); s.idex_mr = 1; s.idex_rw = 1; s.idex_rd = 2;
        s.rs = 2; s.rt = 4; s.uses_rt = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // lw $2 in EX, taken beq $2,$5 in ID: EX rule, MEM rule, then flush
        s = idle(); s.is_branch = 1; s.rs = 2; s.rt = 5; s.uses_rt = 1; s.taken = 1;
        s.idex_mr = 1; s.idex_rw = 1; s.idex_rd = 2;
        applyStimulus(s);
        s.idex_mr = 0; s.idex_rw = 0; s.idex_rd = 0; s.exmem_mr = 1; s.exmem_rd = 2;
        applyStimulus(s);
        s.exmem_mr = 0; s.exmem_rd = 0;
        applyStimulus(s);

        // writer of $0 never stalls a branch
        s = idle(); s.idex_rw = 1; s.idex_rd = 0; s.is_branch = 1;
        s.rs = 0; s.rt = 1; s.uses_rt = 1; s.taken = 1;
        applyStimulus(s);

        // memory busy during a load-use hazard
        s = idle(); s.idex_mr = 1; s.idex_rw = 1; s.idex_rd = 2; s.rs = 2; s.busy = 1;
        repeat (3) applyStimulus(s);
        s.busy = 0;
        applyStimulus(s);

        // long freeze trips the timeout flag, which survives until clr_stats
        s = idle(); s.busy = 1;
        repeat (6) applyStimulus(s);
        repeat (2) applyStimulus(idle());
        s = idle(); s.clr = 1;
        applyStimulus(s);
        applyStimulus(idle());

        // reset in the middle of a freeze
        s = idle(); s.busy = 1;
        repeat (2) applyStimulus(s);
        s.rst = 1;
        applyStimulus(s);
        repeat (2) applyStimulus(idle());

        burst = 0;
        for (int i = 0; i < 1500; i++) begin
            s = idle();
            s.rs       = 5'($urandom_range(0, 3));
            s.rt       = 5'($urandom_range(0, 3));
            s.idex_rd  = 5'($urandom_range(0, 3));
            s.exmem_rd = 5'($urandom_range(0, 3));
            s.uses_rt   = $urandom_range(0, 1) == 1;
            s.is_branch = $urandom_range(0, 2) == 0;
            s.idex_mr   = $urandom_range(0, 2) == 0;
            s.idex_rw   = $urandom_range(0, 1) == 1;
            s.exmem_mr  = $urandom_range(0, 2) == 0;
            s.taken     = $urandom_range(0, 2) == 0;
            s.jump      = $urandom_range(0, 5) == 0;
            s.clr       = $urandom_range(0, 39) == 0;
            s.rst       = $urandom_range(0, 199) == 0;
            if (burst == 0 && $urandom_range(0, 7) == 0) burst = $urandom_range(1, 7);
            s.busy = burst > 0;
            if (burst > 0) burst--;
            applyStimulus(s);
        end

        repeat (3) @(posedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
